psw_pipe: RTL and testbench
===========================

PSW_PIPE -- requirements
Module: psw_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width; legal values are multiples of 4 and >= 8.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 SHALL have port: op  input  2  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBB.
REQ-007 SHALL have port: acc  input  WIDTH  first operand.
REQ-008 SHALL have port: operand  input  WIDTH  second operand.
REQ-009 SHALL have port: psw_clr  input  1  synchronous clear of psw.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-012 SHALL have port: result  output  WIDTH  arithmetic result.
REQ-013 SHALL have port: psw  output  8  status word: [7] CY, [6] AC, [5] OVS, [2] OV, [1] Z, [0] P; bits 4 and 3 always 0.

Function
REQ-014 SHALL be a two-stage pipeline:
- Stage A registers op, acc and operand on acceptance.
- Stage B computes, commits psw, and holds result/out_valid.
REQ-015 SHALL have a latency of 2: input accepted at edge N gives out_valid=1 after edge N+1; throughput is 1 op/cycle when out_ready=1.
REQ-016 SHALL drive in_ready = !A_valid || (stage B can load), where stage B can load = !out_valid || out_ready.
REQ-017 SHALL hold result and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL compute ADD = acc+operand and ADC = acc+operand+CY, with CY = carry out of bit WIDTH-1 and AC = carry out of bit 3.
REQ-019 SHALL compute SUB = acc-operand and SBB = acc-operand-CY, with CY = borrow out of bit WIDTH-1 and AC = borrow out of bit 3.
REQ-020 SHALL set OV to two's-complement signed overflow of the operation.
REQ-021 SHALL set Z=1 iff result==0.
REQ-022 SHALL set P=1 iff result has an even number of ones, counted over all WIDTH bits.
REQ-023 SHALL take the ADC/SBB carry-in from the committed psw[7] at the moment the op enters stage B, so back-to-back ADC/SBB chains use the CY of the immediately preceding op.
REQ-024 SHALL update psw only when an op enters stage B; psw is otherwise held.
REQ-025 SHALL give psw_clr priority over a same-cycle commit: psw becomes 0, while that op's result is still delivered.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force: psw=0, result=0, out_valid=0, A_valid=0, in_ready=0.
REQ-027 SHALL discard any in-flight op when reset is asserted mid-operation.
REQ-028 SHALL assert in_ready=1 on the first clock edge after reset release.

Configuration
REQ-029 SHALL, when PSW_STICKY_OV_EN is defined, set psw[5] (OVS) on any commit with OV=1 and clear it only by psw_clr or reset.
REQ-030 SHALL, when PSW_STICKY_OV_EN is undefined, hold psw[5] at constant 0.

Structure
REQ-031 SHALL place in package psw_pkg:
- op encoding enum: ADD, ADC, SUB, SBB;
- PSW bit-index constants: CY, AC, OVS, OV, Z, P.
REQ-032 SHALL contain one sub-module, psw_flag_calc: combinational, parametrised by WIDTH, mapping (op, acc, operand, cin) to (result, CY, AC, OV, Z, P).

Verification
REQ-033 SHALL cover (all with WIDTH=8) these directed scenarios:
- ADD 0x0F+0x01 -> result 0x10; CY0 AC1 OV0 Z0 P0; out_valid 2 cycles after accept.
- ADD 0x7F+0x01 -> 0x80, OV1 AC1 P0; then psw_clr -> psw 0x00, plus OVS behaviour under each macro setting.
- ADD 0xFF+0x01 followed back-to-back by ADC 0x00+0x00 -> first 0x00 (CY1 Z1 P1), second 0x01 (CY0 Z0 P0).
- SUB 0x00-0x01 -> 0xFF, CY1 AC1 OV0 P1.
- out_ready=0 for 3 cycles with 3 ops offered -> in_ready=0 after the 2nd accept; result stable; all 3 results delivered in order.
- rst_n low with both stages full -> out_valid=0 and psw=0 immediately; no stale result after release.

Source files
------------

// File: rtl/psw_pkg.sv
// psw_pkg: shared definitions for the psw_pipe arithmetic pipeline.
//   psw_op_e   : operation encoding carried on the 2-bit op port
//   CY .. P    : bit positions of the flags within the 8-bit status word
// Optional feature macro used by this block: PSW_STICKY_OV_EN (sticky OVS bit).
package psw_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      ADC = 2'd1,
      SUB = 2'd2,
      SBB = 2'd3
   } psw_op_e;

   localparam int CY  = 7;
   localparam int AC  = 6;
   localparam int OVS = 5;
   localparam int OV  = 2;
   localparam int Z   = 1;
   localparam int P   = 0;

endpackage

// File: rtl/psw_flag_calc.sv
// psw_flag_calc: combinational ALU slice producing a result and its flags.
//   op      : operation (ADD/ADC/SUB/SBB)
//   acc     : first operand
//   operand : second operand
//   cin     : carry/borrow in, only consumed by ADC/SBB
//   result  : WIDTH-bit arithmetic result
//   cy      : carry out (ADD/ADC) or borrow out (SUB/SBB) of the top bit
//   ac      : carry/borrow out of bit 3
//   ov      : two's-complement signed overflow
//   z       : result is zero
//   p       : result has an even number of ones
module psw_flag_calc
   import psw_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  psw_op_e          op,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] operand,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cy,
   output logic             ac,
   output logic             ov,
   output logic             z,
   output logic             p
);

   localparam logic signed [WIDTH:0] SMAX = $signed({2'b00, {(WIDTH-1){1'b1}}});
   localparam logic signed [WIDTH:0] SMIN = $signed({2'b11, {(WIDTH-1){1'b0}}});

   function automatic logic signed [WIDTH:0] sext(input logic [WIDTH-1:0] v);
      return $signed({v[WIDTH-1], v});
   endfunction

   // Exact signed result lies outside the representable WIDTH-bit range.
   function automatic logic sat_ovf(input logic signed [WIDTH:0] v);
      return (v > SMAX) || (v < SMIN);
   endfunction

   function automatic logic even_par(input logic [WIDTH-1:0] v);
      return ~^v;
   endfunction

   logic                    c;
   logic [WIDTH:0]          wide;
   logic signed [WIDTH:0]   sx;

   always_comb begin
      c    = cin & ((op == ADC) || (op == SBB));
      wide = '0;
      sx   = '0;
      if ((op == SUB) || (op == SBB)) begin
         wide = {1'b0, acc} - {1'b0, operand} - {{WIDTH{1'b0}}, c};
         sx   = sext(acc) - sext(operand) - $signed({{WIDTH{1'b0}}, c});
      end else begin
         wide = {1'b0, acc} + {1'b0, operand} + {{WIDTH{1'b0}}, c};
         sx   = sext(acc) + sext(operand) + $signed({{WIDTH{1'b0}}, c});
      end
      result = wide[WIDTH-1:0];
      cy     = wide[WIDTH];
      // Sum/difference bit 4 = a4 ^ b4 ^ (carry or borrow into bit 4),
      // so the carry/borrow out of bit 3 falls out without a nibble adder.
      ac     = acc[4] ^ operand[4] ^ wide[4];
      ov     = sat_ovf(sx);
      z      = (result == '0);
      p      = even_par(result);
   end

endmodule

// File: rtl/psw_pipe.sv
// psw_pipe: two-stage arithmetic pipeline with a program status word.
// Stage A captures the request; stage B computes, commits the PSW and holds
// the result until the consumer takes it.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake
//   op                  : 0 ADD, 1 ADC, 2 SUB, 3 SBB
//   acc, operand        : operands
//   psw_clr             : synchronous PSW clear, wins over a same-cycle commit
//   out_valid, out_ready: result handshake
//   result              : arithmetic result
//   psw                 : [7] CY [6] AC [5] OVS [2] OV [1] Z [0] P, [4:3] = 0
// Macro PSW_STICKY_OV_EN: when defined, OVS accumulates OV until psw_clr or
// reset; when undefined, OVS is always 0.
module psw_pipe
   import psw_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] operand,
   input  logic             psw_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [7:0]       psw
);

   logic             rdy_en;
   logic             vld_p0;
   psw_op_e          op_p0;
   logic [WIDTH-1:0] acc_p0;
   logic [WIDTH-1:0] opnd_p0;
   logic             vld_p1;
   logic [WIDTH-1:0] res_p1;
   logic [7:0]       psw_q;

   logic             b_load;
   logic             accept;
   logic             commit;

   logic [WIDTH-1:0] c_res;
   logic             c_cy, c_ac, c_ov, c_z, c_p;
   logic             ovs_nxt;
   logic [7:0]       psw_nxt;

   // rdy_en keeps in_ready low throughout reset and for the release cycle.
   assign b_load   = !vld_p1 || out_ready;
   assign in_ready = rdy_en && (!vld_p0 || b_load);
   assign accept   = in_valid && in_ready;
   assign commit   = vld_p0 && b_load;

   // ---- Stage A: capture request ----
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0   <= psw_op_e'(op);
         acc_p0  <= acc;
         opnd_p0 <= operand;
      end
   end

   // ---- Stage A -> B: compute ----
   // Carry-in is the committed CY, which already reflects the op that
   // entered stage B on the previous edge.
   psw_flag_calc #(.WIDTH(WIDTH)) u_calc (
      .op      (op_p0),
      .acc     (acc_p0),
      .operand (opnd_p0),
      .cin     (psw_q[CY]),
      .result  (c_res),
      .cy      (c_cy),
      .ac      (c_ac),
      .ov      (c_ov),
      .z       (c_z),
      .p       (c_p)
   );

`ifdef PSW_STICKY_OV_EN
   assign ovs_nxt = psw_q[OVS] | c_ov;
`else
   assign ovs_nxt = 1'b0;
`endif

   assign psw_nxt = {c_cy, c_ac, ovs_nxt, 2'b00, c_ov, c_z, c_p};

   // ---- Stage B: commit PSW, hold result ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en <= 1'b0;
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         res_p1 <= '0;
         psw_q  <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (accept)
            vld_p0 <= 1'b1;
         else if (b_load)
            vld_p0 <= 1'b0;
         if (b_load) begin
            vld_p1 <= vld_p0;
            if (vld_p0)
               res_p1 <= c_res;
         end
         if (psw_clr)
            psw_q <= '0;
         else if (commit)
            psw_q <= psw_nxt;
      end
   end

   assign out_valid = vld_p1;
   assign result    = res_p1;
   assign psw       = psw_q;

endmodule

// File: tb/tb_psw_pipe.sv
module tb_psw_pipe;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] op;
   logic [7:0] acc;
   logic [7:0] operand;
   logic       psw_clr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [7:0] psw;

   psw_pipe #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .acc       (acc),
      .operand   (operand),
      .psw_clr   (psw_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .psw       (psw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] res;
      logic [7:0] psw;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mdl_psw;
   logic [7:0] last_res;
   logic [7:0] held_r;
   logic       held;
   int         n_tests;
   int         n_fail;
   logic       rdone;

`ifdef PSW_STICKY_OV_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model in plain integer arithmetic: returns {psw, result}.
   function automatic logic [15:0] model(input logic [1:0] o, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] ps);
      int c, r, nib, sa, sbv, sr;
      logic [7:0] res;
      logic cy, ac, ov, z, p, ovs;
      c   = (o == 2'd1 || o == 2'd3) ? int'(ps[7]) : 0;
      sa  = (a > 8'd127) ? int'(a) - 256 : int'(a);
      sbv = (b > 8'd127) ? int'(b) - 256 : int'(b);
      if (o[1]) begin
         r   = int'(a) - int'(b) - c;
         nib = int'(a & 8'h0F) - int'(b & 8'h0F) - c;
         sr  = sa - sbv - c;
         cy  = (r < 0);
         ac  = (nib < 0);
      end else begin
         r   = int'(a) + int'(b) + c;
         nib = int'(a & 8'h0F) + int'(b & 8'h0F) + c;
         sr  = sa + sbv + c;
         cy  = (r > 255);
         ac  = (nib > 15);
      end
      res = r[7:0];
      ov  = (sr < -128) || (sr > 127);
      z   = (res == 8'h00);
      p   = (($countones(res) % 2) == 0);
      ovs = STICKY ? (ps[5] | ov) : 1'b0;
      return {cy, ac, ovs, 2'b00, ov, z, p, res};
   endfunction

   // Scoreboard consumer: compares every delivered result and the PSW
   // committed with it; also checks output stability during a stall.
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_result", result, held_r);
         end
         if (out_valid && out_ready) begin
            check_eq("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check_eq("result", result, e.res);
               check_eq("psw", psw, e.psw);
               last_res = result;
            end
         end
         held   = out_valid && !out_ready;
         held_r = result;
      end
   end

   // Offer one op; the expectation is pushed on the negedge before the
   // accepting edge, returns at accept edge + 1.
   task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
      logic       got;
      logic [15:0] m;
      exp_t       e;
      in_valid = 1'b1;
      op       = o;
      acc      = a;
      operand  = b;
      got      = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            m       = model(o, a, b, mdl_psw);
            mdl_psw = m[15:8];
            e.res   = m[7:0];
            e.psw   = m[15:8];
            sb.push_back(e);
            got     = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      check_eq("send_accepted", got, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 50 && (sb.size() != 0 || out_valid); i++) begin
         @(posedge clk);
         #1;
      end
      check_eq("drain_empty", sb.size(), 0);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      held      = 1'b0;
      held_r    = '0;
      last_res  = '0;
      mdl_psw   = '0;
      rdone     = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 2'd0;
      acc       = '0;
      operand   = '0;
      psw_clr   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      #12;
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_psw", psw, 0);
      check_eq("rst_result", result, 0);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("ready_after_release", in_ready, 1);

      // ADD 0x0F+0x01 with latency check
      send(2'd0, 8'h0F, 8'h01);
      check_eq("lat_edge1", out_valid, 0);
      @(posedge clk);
      #1;
      check_eq("lat_edge2", out_valid, 1);
      drain();
      check_eq("add0f_res", last_res, 8'h10);
      check_eq("add0f_psw", psw, 8'h40);

      // ADD 0x7F+0x01: signed overflow, sticky OVS, then clear
      send(2'd0, 8'h7F, 8'h01);
      drain();
      check_eq("add7f_res", last_res, 8'h80);
      check_eq("add7f_psw", psw, STICKY ? 8'h64 : 8'h44);
      send(2'd0, 8'h01, 8'h01);
      drain();
      check_eq("ovs_hold_psw", psw, STICKY ? 8'h20 : 8'h00);
      psw_clr = 1'b1;
      @(posedge clk);
      #1;
      psw_clr = 1'b0;
      mdl_psw = '0;
      check_eq("clr_psw", psw, 8'h00);

      // ADD 0xFF+0x01 then ADC 0x00+0x00 back-to-back
      send(2'd0, 8'hFF, 8'h01);
      send(2'd1, 8'h00, 8'h00);
      drain();
      check_eq("adc_chain_res", last_res, 8'h01);
      check_eq("adc_chain_psw", psw, 8'h00);

      // SUB 0x00-0x01
      send(2'd2, 8'h00, 8'h01);
      drain();
      check_eq("sub_res", last_res, 8'hFF);
      check_eq("sub_psw", psw, 8'hC1);

      // SBB uses the borrow just produced
      send(2'd2, 8'h00, 8'h01);
      send(2'd3, 8'h10, 8'h01);
      drain();
      check_eq("sbb_res", last_res, 8'h0E);

      // psw_clr on the same edge the op commits: clear wins, result delivered
      send(2'd0, 8'h01, 8'h01);
      psw_clr          = 1'b1;
      sb[sb.size()-1].psw = 8'h00;
      mdl_psw          = '0;
      @(posedge clk);
      #1;
      psw_clr = 1'b0;
      check_eq("clr_prio_psw", psw, 8'h00);
      drain();
      check_eq("clr_prio_res", last_res, 8'h02);

      // Back-pressure: three ops offered while out_ready=0
      out_ready = 1'b0;
      fork
         begin
            send(2'd0, 8'h01, 8'h02);
            send(2'd0, 8'h03, 8'h04);
            send(2'd2, 8'h09, 8'h05);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_out_valid", out_valid, 1);
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check_eq("stall_last_res", last_res, 8'h04);

      // Random ops with random back-pressure
      rdone = 1'b0;
      fork
         begin
            for (int k = 0; k < 40; k++)
               send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();

      // Reset with both stages full
      out_ready = 1'b0;
      send(2'd0, 8'h11, 8'h22);
      send(2'd0, 8'h33, 8'h44);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_psw", psw, 0);
      check_eq("midrst_in_ready", in_ready, 0);
      sb.delete();
      mdl_psw = '0;
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midrst_ready_after", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         check_eq("no_stale_valid", out_valid, 0);
         @(posedge clk);
         #1;
      end
      send(2'd0, 8'h05, 8'h06);
      drain();
      check_eq("post_rst_res", last_res, 8'h0B);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
